// File: rtl/cfg_stream_sequencer.sv
// rtl/cfg_stream_sequencer.sv - walks a config ROM and serialises each word MSB-first onto a stream
// Define CFG_CHECKSUM_EN to add checksum_o, the running modulo sum of every accepted beat.
module cfg_stream_sequencer #(
  parameter int         MEM_DEPTH    = 326,
  parameter int         MEM_WIDTH    = 24,
  parameter int         DATA_WIDTH   = 8,
  parameter int         PAUSE_IDX    = 3,
  parameter int         PAUSE_CYCLES = 37_500_000,
  parameter logic [6:0] SLAVE_ADDR   = 7'h74
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic                         mem_rd_o,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  input  logic [MEM_WIDTH-1:0]         mem_data_i,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic                         m_first_o,
  output logic                         m_last_o,
  output logic [7:0]                   dev_addr_o,
  output logic                         busy_o,
`ifdef CFG_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]        checksum_o,
`endif
  output logic                         done_o
);

  localparam int CYCLES = MEM_WIDTH / DATA_WIDTH;
  localparam int AW     = $clog2(MEM_DEPTH);
  localparam int IW     = $clog2(MEM_DEPTH + 1);
  localparam int BW     = $clog2(CYCLES + 1);
  localparam int PW     = $clog2(PAUSE_CYCLES + 1);

  generate
    if (MEM_WIDTH % DATA_WIDTH != 0) begin : g_bad_width
      $error("MEM_WIDTH must be a multiple of DATA_WIDTH");
    end
    if (PAUSE_IDX > MEM_DEPTH) begin : g_bad_pause_idx
      $error("PAUSE_IDX must not exceed MEM_DEPTH");
    end
    if (PAUSE_CYCLES < 1) begin : g_bad_pause_len
      $error("PAUSE_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_SEND, S_PAUSE, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        word_idx;
  logic [BW-1:0]        beat_cnt;
  logic [PW-1:0]        pause_cnt;
  logic [MEM_WIDTH-1:0] shreg;

  logic [IW-1:0] idx_inc;
  logic          last_beat, hs, pause_done, start_ok;

  assign idx_inc    = word_idx + 1'b1;
  assign last_beat  = (beat_cnt == BW'(CYCLES - 1));
  assign hs         = (state == S_SEND) && m_ready_i;
  assign pause_done = (pause_cnt == PW'(PAUSE_CYCLES - 1));
  assign start_ok   = ((state == S_IDLE) || (state == S_DONE)) && start_i;
  assign dev_addr_o = {SLAVE_ADDR, 1'b0};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_i) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_WAIT;
      S_WAIT:         state_nxt = S_SEND;
      S_SEND: begin
        if (m_ready_i && last_beat) begin
          if (idx_inc == IW'(MEM_DEPTH))                          state_nxt = S_DONE;
          else if ((PAUSE_IDX != 0) && (idx_inc == IW'(PAUSE_IDX))) state_nxt = S_PAUSE;
          else                                                     state_nxt = S_FETCH;
        end
      end
      S_PAUSE:        if (pause_done) state_nxt = S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Datapath: word index, beat counter, pause timer and the output shift register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_idx  <= '0;
      beat_cnt  <= '0;
      pause_cnt <= '0;
      shreg     <= '0;
    end else begin
      if (start_ok) begin
        word_idx <= '0;
        beat_cnt <= '0;
      end
      if (state == S_WAIT) begin
        shreg    <= mem_data_i;
        beat_cnt <= '0;
      end
      if (hs) begin
        shreg <= shreg << DATA_WIDTH;
        if (last_beat) begin
          beat_cnt  <= '0;
          word_idx  <= idx_inc;
          pause_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (state == S_PAUSE) pause_cnt <= pause_cnt + 1'b1;
    end
  end

`ifdef CFG_CHECKSUM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) checksum_o <= '0;
    else if (hs)           checksum_o <= checksum_o + m_data_o;
  end
`endif

  always_comb begin
    mem_rd_o   = 1'b0;
    mem_addr_o = '0;
    m_valid_o  = 1'b0;
    m_first_o  = 1'b0;
    m_last_o   = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    m_data_o   = shreg[MEM_WIDTH-1 -: DATA_WIDTH];
    case (state)
      S_FETCH: begin
        busy_o     = 1'b1;
        mem_rd_o   = 1'b1;
        mem_addr_o = word_idx[AW-1:0];
      end
      S_WAIT, S_PAUSE: busy_o = 1'b1;
      S_SEND: begin
        busy_o    = 1'b1;
        m_valid_o = 1'b1;
        m_first_o = (beat_cnt == '0);
        m_last_o  = last_beat;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cfg_stream_sequencer.sv
// tb/tb_cfg_stream_sequencer.sv - randomized bench for cfg_stream_sequencer, paused and pause-free instances
module tb_cfg_stream_sequencer;

  localparam int P_CYC = 10;
  localparam int NBEAT = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ready;
  logic [1:0]       rd, valid, first, last, busy, done;
  logic [1:0][1:0]  addr;
  logic [1:0][7:0]  data, dev;
  logic [1:0][23:0] rdata;
`ifdef CFG_CHECKSUM_EN
  logic [1:0][7:0]  cks;
`endif

  logic [23:0] rom [4];
  logic [7:0]  lit [NBEAT];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  cfg_stream_sequencer #(.MEM_DEPTH(4), .MEM_WIDTH(24), .DATA_WIDTH(8), .PAUSE_IDX(2),
                         .PAUSE_CYCLES(P_CYC), .SLAVE_ADDR(7'h74)) u_pause (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_rd_o(rd[0]), .mem_addr_o(addr[0]),
    .mem_data_i(rdata[0]), .m_data_o(data[0]), .m_valid_o(valid[0]), .m_ready_i(ready),
    .m_first_o(first[0]), .m_last_o(last[0]), .dev_addr_o(dev[0]), .busy_o(busy[0]),
`ifdef CFG_CHECKSUM_EN
    .checksum_o(cks[0]),
`endif
    .done_o(done[0]));

  cfg_stream_sequencer #(.MEM_DEPTH(4), .MEM_WIDTH(24), .DATA_WIDTH(8), .PAUSE_IDX(0),
                         .PAUSE_CYCLES(P_CYC), .SLAVE_ADDR(7'h74)) u_nopause (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_rd_o(rd[1]), .mem_addr_o(addr[1]),
    .mem_data_i(rdata[1]), .m_data_o(data[1]), .m_valid_o(valid[1]), .m_ready_i(ready),
    .m_first_o(first[1]), .m_last_o(last[1]), .dev_addr_o(dev[1]), .busy_o(busy[1]),
`ifdef CFG_CHECKSUM_EN
    .checksum_o(cks[1]),
`endif
    .done_o(done[1]));

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rd[i]) rdata[i] <= rom[addr[i]];
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[u%0d] cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] beat(input int kk);
    logic [23:0] w;
    w = rom[kk / 3];
    return w[8 * (2 - kk % 3) +: 8];
  endfunction

  // Transaction-level model: which beat is due, when the next word becomes valid, running/done.
  int          k [2];
  int          valid_from [2];
  bit          running [2], done_m [2], post_rst [2];
  logic [7:0]  cks_m [2];
  bit          pv [2], pr [2], pf [2], pl [2];
  logic [7:0]  pd [2];
  int          hs_cyc0[$], hs_cyc1[$];
  logic [7:0]  hs_dat0[$], hs_dat1[$];

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit vexp;
      int pidx;
      pidx = (i == 0) ? 2 : 0;
      vexp = running[i] && (cyc >= valid_from[i]) && (k[i] < NBEAT);
      if (post_rst[i]) begin
        chk("rst_valid", i, valid[i], 0);
        chk("rst_rd",    i, rd[i],    0);
        chk("rst_busy",  i, busy[i],  0);
        chk("rst_done",  i, done[i],  0);
        chk("rst_first", i, first[i], 0);
        chk("rst_last",  i, last[i],  0);
        chk("rst_data",  i, data[i],  0);
        chk("rst_addr",  i, addr[i],  0);
`ifdef CFG_CHECKSUM_EN
        chk("rst_cks",   i, cks[i],   0);
`endif
      end else begin
        chk("valid",  i, valid[i], vexp);
        chk("busy",   i, busy[i],  running[i]);
        chk("done",   i, done[i],  done_m[i]);
        chk("mem_rd", i, rd[i],    running[i] && (cyc == valid_from[i] - 2));
        if (rd[i]) chk("mem_addr", i, addr[i], k[i] / 3);
        if (vexp) begin
          chk("data",  i, data[i],  beat(k[i]));
          chk("first", i, first[i], (k[i] % 3) == 0);
          chk("last",  i, last[i],  (k[i] % 3) == 2);
        end
        if (pv[i] && !pr[i] && valid[i]) begin
          chk("stable_data",  i, data[i],  pd[i]);
          chk("stable_first", i, first[i], pf[i]);
          chk("stable_last",  i, last[i],  pl[i]);
        end
`ifdef CFG_CHECKSUM_EN
        if (done_m[i]) chk("checksum", i, cks[i], cks_m[i]);
`endif
      end
      pv[i] = valid[i]; pr[i] = ready; pd[i] = data[i]; pf[i] = first[i]; pl[i] = last[i];
      post_rst[i] = 1'b0;
      if (rst) begin
        running[i] = 0; done_m[i] = 0; k[i] = 0; post_rst[i] = 1; cks_m[i] = '0;
      end else if (start && !running[i]) begin
        running[i] = 1; done_m[i] = 0; k[i] = 0; cks_m[i] = '0;
        valid_from[i] = cyc + 3;
      end else if (vexp && ready) begin
        if (i == 0) begin hs_cyc0.push_back(cyc); hs_dat0.push_back(data[i]); end
        else        begin hs_cyc1.push_back(cyc); hs_dat1.push_back(data[i]); end
        cks_m[i] = cks_m[i] + beat(k[i]);
        k[i]++;
        if (k[i] % 3 == 0) begin
          if (k[i] == NBEAT) begin
            running[i] = 0; done_m[i] = 1;
          end else begin
            valid_from[i] = cyc + 3 + (((pidx != 0) && (k[i] / 3 == pidx)) ? P_CYC : 0);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    hs_cyc0.delete(); hs_cyc1.delete(); hs_dat0.delete(); hs_dat1.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done != 2'b11 && n < budget) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 0, done == 2'b11, 1);
  endtask

  task automatic check_stream(input string name);
    chk({name, "_count"}, 0, hs_dat0.size(), NBEAT);
    chk({name, "_count"}, 1, hs_dat1.size(), NBEAT);
    for (int j = 0; j < NBEAT; j++) begin
      if (j < hs_dat0.size()) chk({name, "_beat"}, 0, hs_dat0[j], lit[j]);
      if (j < hs_dat1.size()) chk({name, "_beat"}, 1, hs_dat1[j], lit[j]);
    end
  endtask

  initial begin
    int n;
    rom[0] = 24'h0B24C0; rom[1] = 24'h0B2500; rom[2] = 24'h051403; rom[3] = 24'h000001;
    lit[0] = 8'h0B; lit[1] = 8'h24; lit[2]  = 8'hC0; lit[3]  = 8'h0B;
    lit[4] = 8'h25; lit[5] = 8'h00; lit[6]  = 8'h05; lit[7]  = 8'h14;
    lit[8] = 8'h03; lit[9] = 8'h00; lit[10] = 8'h00; lit[11] = 8'h01;
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    chk("dev_addr", 0, dev[0], 8'hE8);
    chk("dev_addr", 1, dev[1], 8'hE8);

    // Full-rate run: literal stream, gap lengths and first-beat latency.
    clear_capture();
    pulse_start();
    wait_done(200, "run1");
    check_stream("run1");
    if (hs_cyc0.size() == NBEAT) begin
      chk("pause_gap", 0, hs_cyc0[6] - hs_cyc0[5], P_CYC + 3);
      chk("word_gap",  0, hs_cyc0[3] - hs_cyc0[2], 3);
    end
    if (hs_cyc1.size() == NBEAT) begin
      chk("word_gap", 1, hs_cyc1[3] - hs_cyc1[2], 3);
      chk("word_gap", 1, hs_cyc1[6] - hs_cyc1[5], 3);
    end
    chk("run1_busy", 0, busy, 2'b00);
`ifdef CFG_CHECKSUM_EN
    chk("run1_cks", 0, cks[0], 8'h3C);
    chk("run1_cks", 1, cks[1], 8'h3C);
`endif

    // Restart from DONE under ~30% ready, with a stray start while busy.
    clear_capture();
    pulse_start();
    chk("restart_done_clr", 0, done, 2'b00);
    n = 0;
    while (!(done == 2'b11 && n > 6) && n < 3000) begin
      ready = ($urandom_range(0, 9) < 3);
      start = (n == 5);
      step();
      n++;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("run2_timeout", 0, done == 2'b11, 1);
    check_stream("run2");

    // Reset in the fifth pause cycle, then replay.
    clear_capture();
    pulse_start();
    n = 0;
    while (hs_cyc0.size() < 6 && n < 200) begin
      step();
      n++;
    end
    chk("reach_pause", 0, hs_cyc0.size(), 6);
    repeat (4) step();
    chk("in_pause", 0, {busy[0], valid[0]}, 2'b10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("after_rst_busy", 0, busy, 2'b00);
    chk("after_rst_valid", 0, valid, 2'b00);
`ifdef CFG_CHECKSUM_EN
    chk("after_rst_cks", 0, cks[0], 8'h00);
`endif
    step();
    clear_capture();
    pulse_start();
    wait_done(200, "run3");
    check_stream("run3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
